// File: rtl/trap_ctrl_if.sv
// Bundle between the core / CSR register file and the trap sequencer.
// The "slave" modport is the trap_ctrl view; "master" is the core/CSR-file view.
interface trap_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
);
  // Core-side trap/return requests
  logic              trap_valid_i;
  logic              mret_valid_i;
  logic [XLEN-1:0]   pc_i;
  logic [XLEN-1:0]   cause_i;

  // Instruction-side CSR access requests
  logic [CSR_AW-1:0] inst_csr_raddr_i;
  logic              inst_csr_rena_i;
  logic [CSR_AW-1:0] inst_csr_waddr_i;
  logic [XLEN-1:0]   inst_csr_wdata_i;
  logic              inst_csr_wena_i;

  // CSR register file port (combinational read data)
  logic [XLEN-1:0]   csr_rdata_i;
  logic [CSR_AW-1:0] csr_raddr_o;
  logic              csr_rena_o;
  logic [CSR_AW-1:0] csr_waddr_o;
  logic [XLEN-1:0]   csr_wdata_o;
  logic              csr_wena_o;

  // Pipeline control
  logic              stall_o;
  logic              redirect_valid_o;
  logic [XLEN-1:0]   redirect_pc_o;

  modport slave (
    input  trap_valid_i, mret_valid_i, pc_i, cause_i,
    input  inst_csr_raddr_i, inst_csr_rena_i,
    input  inst_csr_waddr_i, inst_csr_wdata_i, inst_csr_wena_i,
    input  csr_rdata_i,
    output csr_raddr_o, csr_rena_o, csr_waddr_o, csr_wdata_o, csr_wena_o,
    output stall_o, redirect_valid_o, redirect_pc_o
  );

  modport master (
    output trap_valid_i, mret_valid_i, pc_i, cause_i,
    output inst_csr_raddr_i, inst_csr_rena_i,
    output inst_csr_waddr_i, inst_csr_wdata_i, inst_csr_wena_i,
    output csr_rdata_i,
    input  csr_raddr_o, csr_rena_o, csr_waddr_o, csr_wdata_o, csr_wena_o,
    input  stall_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer in front of the CSR register file. Owns the file's single
// read and write port: in IDLE the instruction-side accesses pass through;
// on ecall/mret it walks an ordered CSR sequence while stalling the core and
// ends with a one-cycle PC redirect.
module trap_ctrl #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic       clk,
  input  logic       rst,
  trap_ctrl_if.slave bus
);

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] CSR_MEPC    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = CSR_AW'(12'h342);

  // mstatus field positions
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_STAT,
    T_VEC,
    R_STAT,
    R_EPC
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cause_q;
  logic            accept_trap;
  logic            accept_mret;

  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M; every other bit kept.
  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r                = s;
    r[MPIE_BIT]      = s[MIE_BIT];
    r[MIE_BIT]       = 1'b0;
    r[MPP_HI:MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <- MPIE, MPIE <- 1, MPP <- U; every other bit kept.
  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] r;
    r                = s;
    r[MIE_BIT]       = s[MPIE_BIT];
    r[MPIE_BIT]      = 1'b1;
    r[MPP_HI:MPP_LO] = 2'b00;
    return r;
  endfunction

  // A trap takes priority when both requests arrive together.
  assign accept_trap = (state_q == IDLE) && bus.trap_valid_i;
  assign accept_mret = (state_q == IDLE) && bus.mret_valid_i && !bus.trap_valid_i;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture the trapping PC and cause on the accept cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q   <= '0;
      cause_q <= '0;
    end else if (accept_trap) begin
      epc_q   <= bus.pc_i;
      cause_q <= bus.cause_i;
    end
  end

  // Next-state logic: fixed walk through each sequence.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept_trap)      state_d = T_EPC;
        else if (accept_mret) state_d = R_STAT;
      end
      T_EPC:   state_d = T_CAUSE;
      T_CAUSE: state_d = T_STAT;
      T_STAT:  state_d = T_VEC;
      T_VEC:   state_d = IDLE;
      R_STAT:  state_d = R_EPC;
      R_EPC:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CSR port steering, stall and redirect. Everything is held at zero while
  // reset is asserted so a sequence interrupted by reset emits nothing more.
  always_comb begin
    bus.csr_raddr_o      = '0;
    bus.csr_rena_o       = 1'b0;
    bus.csr_waddr_o      = '0;
    bus.csr_wdata_o      = '0;
    bus.csr_wena_o       = 1'b0;
    bus.stall_o          = 1'b0;
    bus.redirect_valid_o = 1'b0;
    bus.redirect_pc_o    = '0;

    if (!rst) begin
      bus.stall_o = (state_q != IDLE) || bus.trap_valid_i || bus.mret_valid_i;

      unique case (state_q)
        IDLE: begin
          // Reads always pass through; writes are dropped on an accept cycle
          // so the instruction being trapped cannot modify CSR state.
          bus.csr_raddr_o = bus.inst_csr_raddr_i;
          bus.csr_rena_o  = bus.inst_csr_rena_i;
          if (!bus.trap_valid_i && !bus.mret_valid_i) begin
            bus.csr_waddr_o = bus.inst_csr_waddr_i;
            bus.csr_wdata_o = bus.inst_csr_wdata_i;
            bus.csr_wena_o  = bus.inst_csr_wena_i;
          end
        end
        T_EPC: begin
          bus.csr_waddr_o = CSR_MEPC;
          bus.csr_wdata_o = epc_q;
          bus.csr_wena_o  = 1'b1;
        end
        T_CAUSE: begin
          bus.csr_waddr_o = CSR_MCAUSE;
          bus.csr_wdata_o = cause_q;
          bus.csr_wena_o  = 1'b1;
        end
        T_STAT: begin
          // Read-modify-write in one cycle through the combinational read port.
          bus.csr_raddr_o = CSR_MSTATUS;
          bus.csr_rena_o  = 1'b1;
          bus.csr_waddr_o = CSR_MSTATUS;
          bus.csr_wdata_o = mstatus_on_trap(bus.csr_rdata_i);
          bus.csr_wena_o  = 1'b1;
        end
        T_VEC: begin
          // Direct mode only: mode bits are masked off the vector base.
          bus.csr_raddr_o      = CSR_MTVEC;
          bus.csr_rena_o       = 1'b1;
          bus.redirect_valid_o = 1'b1;
          bus.redirect_pc_o    = {bus.csr_rdata_i[XLEN-1:2], 2'b00};
        end
        R_STAT: begin
          bus.csr_raddr_o = CSR_MSTATUS;
          bus.csr_rena_o  = 1'b1;
          bus.csr_waddr_o = CSR_MSTATUS;
          bus.csr_wdata_o = mstatus_on_mret(bus.csr_rdata_i);
          bus.csr_wena_o  = 1'b1;
        end
        R_EPC: begin
          bus.csr_raddr_o      = CSR_MEPC;
          bus.csr_rena_o       = 1'b1;
          bus.redirect_valid_o = 1'b1;
          bus.redirect_pc_o    = bus.csr_rdata_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a small CSR file model answers reads, directed stimulus
// pushes expected CSR writes / redirects into a queue, and a negedge monitor
// pops and compares every write or redirect the DUT presents.
module tb_trap_ctrl;

  localparam int XLEN   = 32;
  localparam int CSR_AW = 12;

  typedef struct packed {
    logic              is_redir;
    logic [CSR_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } sb_item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  sb_item_t sb_q[$];

  // CSR file model (environment only)
  logic [XLEN-1:0] m_mstatus = '0;
  logic [XLEN-1:0] m_mtvec   = '0;
  logic [XLEN-1:0] m_mepc    = '0;
  logic [XLEN-1:0] m_mcause  = '0;
  logic [XLEN-1:0] m_rdata;

  trap_ctrl_if #(.XLEN(XLEN), .CSR_AW(CSR_AW)) bus ();

  trap_ctrl #(.XLEN(XLEN), .CSR_AW(CSR_AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_rdata = '0;
    case (bus.csr_raddr_o)
      12'h300: m_rdata = m_mstatus;
      12'h305: m_rdata = m_mtvec;
      12'h341: m_rdata = m_mepc;
      12'h342: m_rdata = m_mcause;
      default: m_rdata = '0;
    endcase
  end
  assign bus.csr_rdata_i = m_rdata;

  always @(posedge clk) begin
    if (bus.csr_wena_o) begin
      case (bus.csr_waddr_o)
        12'h300: m_mstatus <= bus.csr_wdata_o;
        12'h305: m_mtvec   <= bus.csr_wdata_o;
        12'h341: m_mepc    <= bus.csr_wdata_o;
        12'h342: m_mcause  <= bus.csr_wdata_o;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write or redirect must match the next queued expectation.
  always @(negedge clk) begin
    sb_item_t got;
    sb_item_t exp;
    if (!rst) begin
      if (bus.csr_wena_o) begin
        got = '{is_redir: 1'b0, addr: bus.csr_waddr_o, data: bus.csr_wdata_o};
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_write actual=0x%0h expected=none", got);
        end else begin
          exp = sb_q.pop_front();
          check("sb_write", 64'(got), 64'(exp));
        end
      end
      if (bus.redirect_valid_o) begin
        got = '{is_redir: 1'b1, addr: '0, data: bus.redirect_pc_o};
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_redirect actual=0x%0h expected=none", got);
        end else begin
          exp = sb_q.pop_front();
          check("sb_redirect", 64'(got), 64'(exp));
        end
      end
    end
  end

  task automatic push_wr(input logic [CSR_AW-1:0] a, input logic [XLEN-1:0] d);
    sb_q.push_back('{is_redir: 1'b0, addr: a, data: d});
  endtask

  task automatic push_redir(input logic [XLEN-1:0] pc);
    sb_q.push_back('{is_redir: 1'b1, addr: '0, data: pc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle pass-through write: one CSR write expected, no stall.
  task automatic inst_write(input logic [CSR_AW-1:0] a, input logic [XLEN-1:0] d);
    bus.inst_csr_waddr_i = a;
    bus.inst_csr_wdata_i = d;
    bus.inst_csr_wena_i  = 1'b1;
    push_wr(a, d);
    @(negedge clk);
    check("pt_stall", 64'(bus.stall_o), 64'd0);
    tick();
    bus.inst_csr_wena_i = 1'b0;
  endtask

  // ecall sequence; optional mret raised too and optional inst write in T_STAT.
  task automatic trap_seq(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] cause,
                          input logic with_mret, input logic [XLEN-1:0] ms_exp,
                          input logic [XLEN-1:0] target, input logic inject);
    bus.trap_valid_i     = 1'b1;
    bus.mret_valid_i     = with_mret;
    bus.pc_i             = pc;
    bus.cause_i          = cause;
    bus.inst_csr_waddr_i = 12'h305;
    bus.inst_csr_wdata_i = 32'hDEAD_0000;
    bus.inst_csr_wena_i  = 1'b1;   // must be dropped on the accept cycle
    push_wr(12'h341, pc);
    push_wr(12'h342, cause);
    push_wr(12'h300, ms_exp);
    push_redir(target);
    @(negedge clk);
    check("trap_c0_stall", 64'(bus.stall_o), 64'd1);
    check("trap_c0_wena", 64'(bus.csr_wena_o), 64'd0);
    tick();
    bus.trap_valid_i    = 1'b0;
    bus.mret_valid_i    = 1'b0;
    bus.inst_csr_wena_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bus.inst_csr_wena_i = inject && (c == 3);
      @(negedge clk);
      check($sformatf("trap_c%0d_stall", c), 64'(bus.stall_o), 64'd1);
      check($sformatf("trap_c%0d_redir", c), 64'(bus.redirect_valid_o), 64'(c == 4));
      if (inject && c == 3)
        check("trap_tstat_waddr", 64'(bus.csr_waddr_o), 64'h300);
      tick();
    end
    bus.inst_csr_wena_i = 1'b0;
    @(negedge clk);
    check("trap_after_stall", 64'(bus.stall_o), 64'd0);
    tick();
  endtask

  task automatic mret_seq(input logic [XLEN-1:0] ms_exp, input logic [XLEN-1:0] target);
    bus.mret_valid_i = 1'b1;
    push_wr(12'h300, ms_exp);
    push_redir(target);
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      check($sformatf("mret_c%0d_stall", c), 64'(bus.stall_o), 64'd1);
      check($sformatf("mret_c%0d_redir", c), 64'(bus.redirect_valid_o), 64'(c == 2));
      tick();
      bus.mret_valid_i = 1'b0;
    end
    @(negedge clk);
    check("mret_after_stall", 64'(bus.stall_o), 64'd0);
    tick();
  endtask

  initial begin
    bus.trap_valid_i     = 1'b0;
    bus.mret_valid_i     = 1'b0;
    bus.pc_i             = '0;
    bus.cause_i          = '0;
    bus.inst_csr_raddr_i = 12'h305;
    bus.inst_csr_rena_i  = 1'b1;
    bus.inst_csr_waddr_i = 12'h341;
    bus.inst_csr_wdata_i = 32'h1234_5678;
    bus.inst_csr_wena_i  = 1'b1;   // outputs must stay zero under reset

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wena", 64'(bus.csr_wena_o), 64'd0);
    check("rst_rena", 64'(bus.csr_rena_o), 64'd0);
    check("rst_stall", 64'(bus.stall_o), 64'd0);
    check("rst_redir", 64'(bus.redirect_valid_o), 64'd0);
    tick();
    rst = 1'b0;
    bus.inst_csr_wena_i = 1'b0;
    bus.inst_csr_rena_i = 1'b0;

    // 1. Idle pass-through, also seeds mtvec and mstatus
    inst_write(12'h305, 32'h8000_0100);
    inst_write(12'h300, 32'h0000_0008);

    // 2. ecall: mstatus 0x8 -> 0x1880, redirect to mtvec
    trap_seq(32'h8000_0010, 32'd11, 1'b0, 32'h0000_1880, 32'h8000_0100, 1'b0);

    // 3. mret: mstatus 0x1880 -> 0x88, redirect to mepc
    inst_write(12'h341, 32'h8000_0014);
    mret_seq(32'h0000_0088, 32'h8000_0014);

    // 4. trap and mret together: trap wins; mstatus 0x88 -> 0x1880
    trap_seq(32'h8000_0020, 32'd11, 1'b1, 32'h0000_1880, 32'h8000_0100, 1'b0);

    // 5. reset during T_CAUSE: only MEPC write, no redirect afterwards
    bus.trap_valid_i = 1'b1;
    bus.pc_i         = 32'h8000_0030;
    bus.cause_i      = 32'd11;
    push_wr(12'h341, 32'h8000_0030);
    tick();                         // now in T_EPC
    bus.trap_valid_i = 1'b0;
    tick();                         // now in T_CAUSE
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_wena", 64'(bus.csr_wena_o), 64'd0);
    check("rstmid_redir", 64'(bus.redirect_valid_o), 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstmid_after_stall", 64'(bus.stall_o), 64'd0);
      check("rstmid_after_redir", 64'(bus.redirect_valid_o), 64'd0);
      check("rstmid_after_wena", 64'(bus.csr_wena_o), 64'd0);
      tick();
    end
    check("rstmid_mstatus_kept", 64'(m_mstatus), 64'h1880);

    // 6. inst write during T_STAT ignored; mstatus 0x1880 -> 0x1800
    trap_seq(32'h8000_0040, 32'd11, 1'b0, 32'h0000_1800, 32'h8000_0100, 1'b1);
    check("final_mtvec_untouched", 64'(m_mtvec), 64'h8000_0100);

    repeat (2) tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
